// File: rtl/axi_reg_slice_pkg.sv
// axi_reg_slice_pkg: channel modes, AXI sideband field widths, skid FSM states and a saturating increment helper
package axi_reg_slice_pkg;
    localparam int MODE_BYPASS = 0;
    localparam int MODE_FWD    = 1;
    localparam int MODE_FULL   = 2;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int LOCK_W  = 2;
    localparam int PROT_W  = 3;
    localparam int CACHE_W = 4;
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} skid_state_t;
    function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic en);
        return (en && c != '1) ? c + 32'd1 : c;
    endfunction
endpackage

// File: rtl/axi_slice_stage.sv
// axi_slice_stage: one valid/ready channel stage, selectable as bypass, forward register or full skid buffer
module axi_slice_stage
    import axi_reg_slice_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MODE  = MODE_FULL
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_src_valid,
    output logic             o_src_ready,
    input  logic [WIDTH-1:0] i_src_pld,
    output logic             o_dst_valid,
    input  logic             i_dst_ready,
    output logic [WIDTH-1:0] o_dst_pld
);
    generate
        if (MODE == MODE_BYPASS) begin : g_bypass
            logic w_unused;
            assign w_unused    = &{1'b0, i_clk, i_rst};
            assign o_dst_valid = i_src_valid;
            assign o_dst_pld   = i_src_pld;
            assign o_src_ready = i_dst_ready;
        end else if (MODE == MODE_FWD) begin : g_fwd
            logic             r_vld;
            logic [WIDTH-1:0] r_pld;
            assign o_src_ready = !i_rst && (!r_vld || i_dst_ready);
            assign o_dst_valid = r_vld;
            assign o_dst_pld   = r_pld;
            // Single register: reload whenever the slot is free or being drained
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_vld <= 1'b0;
                    r_pld <= '0;
                end else if (o_src_ready) begin
                    r_vld <= i_src_valid;
                    if (i_src_valid) r_pld <= i_src_pld;
                end
            end
        end else begin : g_full
            skid_state_t      r_state;
            logic             r_rdy;
            logic [WIDTH-1:0] r_main;
            logic [WIDTH-1:0] r_skid;
            logic             w_push;
            logic             w_pop;
            assign o_src_ready = r_rdy && !i_rst;
            assign o_dst_valid = r_state != ST_EMPTY;
            assign o_dst_pld   = r_main;
            assign w_push      = i_src_valid && o_src_ready;
            assign w_pop       = o_dst_valid && i_dst_ready;
            // Skid FSM: r_rdy tracks "next state is not TWO" so the ready path is a flop
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_state <= ST_EMPTY;
                    r_rdy   <= 1'b1;
                    r_main  <= '0;
                    r_skid  <= '0;
                end else begin
                    case (r_state)
                        ST_EMPTY: if (w_push) begin
                            r_state <= ST_ONE;
                            r_main  <= i_src_pld;
                        end
                        ST_ONE: if (w_push && !w_pop) begin
                            r_state <= ST_TWO;
                            r_skid  <= i_src_pld;
                            r_rdy   <= 1'b0;
                        end else if (w_push) begin
                            r_main  <= i_src_pld;
                        end else if (w_pop) begin
                            r_state <= ST_EMPTY;
                        end
                        ST_TWO: if (w_pop) begin
                            r_state <= ST_ONE;
                            r_main  <= r_skid;
                            r_rdy   <= 1'b1;
                        end
                        default: r_state <= ST_EMPTY;
                    endcase
                end
            end
        end
    endgenerate
endmodule

// File: rtl/axi_reg_slice.sv
// axi_reg_slice: five-channel AXI register slice; optional AXI_REG_SLICE_STATS_EN adds completion/stall counters
module axi_reg_slice
    import axi_reg_slice_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 1024,
    parameter int ID_W    = 8,
    parameter int LEN_W   = 10,
    parameter int RESP_W  = 4,
    parameter int AW_MODE = 2,
    parameter int W_MODE  = 2,
    parameter int AR_MODE = 2,
    parameter int R_MODE  = 2,
    parameter int B_MODE  = 2,
    localparam int AW_W = ADDR_W + LEN_W + SIZE_W + BURST_W + LOCK_W + PROT_W + CACHE_W + ID_W,
    localparam int AR_W = AW_W,
    localparam int W_W  = DATA_W + DATA_W / 8 + 1 + ID_W,
    localparam int R_W  = DATA_W + 1 + RESP_W + ID_W,
    localparam int B_W  = RESP_W + ID_W
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic            awvalid_m1,
    output logic            awready_m1,
    input  logic [AW_W-1:0] aw_pld_m1,
    output logic            awvalid_s1,
    input  logic            awready_s1,
    output logic [AW_W-1:0] aw_pld_s1,
    input  logic            wvalid_m1,
    output logic            wready_m1,
    input  logic [W_W-1:0]  w_pld_m1,
    output logic            wvalid_s1,
    input  logic            wready_s1,
    output logic [W_W-1:0]  w_pld_s1,
    input  logic            arvalid_m1,
    output logic            arready_m1,
    input  logic [AR_W-1:0] ar_pld_m1,
    output logic            arvalid_s1,
    input  logic            arready_s1,
    output logic [AR_W-1:0] ar_pld_s1,
    input  logic            rvalid_s1,
    output logic            rready_s1,
    input  logic [R_W-1:0]  r_pld_s1,
    output logic            rvalid_m1,
    input  logic            rready_m1,
    output logic [R_W-1:0]  r_pld_m1,
    input  logic            bvalid_s1,
    output logic            bready_s1,
    input  logic [B_W-1:0]  b_pld_s1,
    output logic            bvalid_m1,
    input  logic            bready_m1,
    output logic [B_W-1:0]  b_pld_m1
`ifdef AXI_REG_SLICE_STATS_EN
    ,
    output logic [31:0]     wr_done_cnt,
    output logic [31:0]     rd_done_cnt,
    output logic [31:0]     stall_cnt
`endif
);
    axi_slice_stage #(.WIDTH(AW_W), .MODE(AW_MODE)) u_aw (
        .i_clk(aclk), .i_rst(areset),
        .i_src_valid(awvalid_m1), .o_src_ready(awready_m1), .i_src_pld(aw_pld_m1),
        .o_dst_valid(awvalid_s1), .i_dst_ready(awready_s1), .o_dst_pld(aw_pld_s1)
    );
    axi_slice_stage #(.WIDTH(W_W), .MODE(W_MODE)) u_w (
        .i_clk(aclk), .i_rst(areset),
        .i_src_valid(wvalid_m1), .o_src_ready(wready_m1), .i_src_pld(w_pld_m1),
        .o_dst_valid(wvalid_s1), .i_dst_ready(wready_s1), .o_dst_pld(w_pld_s1)
    );
    axi_slice_stage #(.WIDTH(AR_W), .MODE(AR_MODE)) u_ar (
        .i_clk(aclk), .i_rst(areset),
        .i_src_valid(arvalid_m1), .o_src_ready(arready_m1), .i_src_pld(ar_pld_m1),
        .o_dst_valid(arvalid_s1), .i_dst_ready(arready_s1), .o_dst_pld(ar_pld_s1)
    );
    axi_slice_stage #(.WIDTH(R_W), .MODE(R_MODE)) u_r (
        .i_clk(aclk), .i_rst(areset),
        .i_src_valid(rvalid_s1), .o_src_ready(rready_s1), .i_src_pld(r_pld_s1),
        .o_dst_valid(rvalid_m1), .i_dst_ready(rready_m1), .o_dst_pld(r_pld_m1)
    );
    axi_slice_stage #(.WIDTH(B_W), .MODE(B_MODE)) u_b (
        .i_clk(aclk), .i_rst(areset),
        .i_src_valid(bvalid_s1), .o_src_ready(bready_s1), .i_src_pld(b_pld_s1),
        .o_dst_valid(bvalid_m1), .i_dst_ready(bready_m1), .o_dst_pld(b_pld_m1)
    );
`ifdef AXI_REG_SLICE_STATS_EN
    logic w_wr_hs;
    logic w_rd_last;
    logic w_stall;
    assign w_wr_hs   = bvalid_m1 && bready_m1;
    assign w_rd_last = rvalid_m1 && rready_m1 && r_pld_m1[RESP_W+ID_W];
    assign w_stall   = (awvalid_s1 && !awready_s1) || (wvalid_s1 && !wready_s1) || (arvalid_s1 && !arready_s1);
    // Saturating event counters
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_done_cnt <= '0;
            rd_done_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            wr_done_cnt <= sat_inc(wr_done_cnt, w_wr_hs);
            rd_done_cnt <= sat_inc(rd_done_cnt, w_rd_last);
            stall_cnt   <= sat_inc(stall_cnt, w_stall);
        end
    end
`endif
endmodule

// File: tb/tb_axi_reg_slice.sv
// tb_axi_reg_slice: scoreboard bench for axi_reg_slice (AW/W/AR full skid, R forward, B bypass)
module tb_axi_reg_slice;
    localparam int ADDR_W = 16, DATA_W = 32, ID_W = 8, LEN_W = 8, RESP_W = 2;
    localparam int AW_W = ADDR_W + LEN_W + 14 + ID_W;
    localparam int W_W  = DATA_W + DATA_W / 8 + 1 + ID_W;
    localparam int R_W  = DATA_W + 1 + RESP_W + ID_W;
    localparam int B_W  = RESP_W + ID_W;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    logic awvalid_m1, awready_m1, awvalid_s1, awready_s1;
    logic wvalid_m1, wready_m1, wvalid_s1, wready_s1;
    logic arvalid_m1, arready_m1, arvalid_s1, arready_s1;
    logic rvalid_s1, rready_s1, rvalid_m1, rready_m1;
    logic bvalid_s1, bready_s1, bvalid_m1, bready_m1;
    logic [AW_W-1:0] aw_pld_m1, aw_pld_s1, ar_pld_m1, ar_pld_s1;
    logic [W_W-1:0]  w_pld_m1, w_pld_s1;
    logic [R_W-1:0]  r_pld_s1, r_pld_m1;
    logic [B_W-1:0]  b_pld_s1, b_pld_m1;
`ifdef AXI_REG_SLICE_STATS_EN
    logic [31:0] wr_done_cnt, rd_done_cnt, stall_cnt;
`endif

    axi_reg_slice #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W), .RESP_W(RESP_W),
        .AW_MODE(2), .W_MODE(2), .AR_MODE(2), .R_MODE(1), .B_MODE(0)
    ) dut (
        .aclk(aclk), .areset(areset),
        .awvalid_m1(awvalid_m1), .awready_m1(awready_m1), .aw_pld_m1(aw_pld_m1),
        .awvalid_s1(awvalid_s1), .awready_s1(awready_s1), .aw_pld_s1(aw_pld_s1),
        .wvalid_m1(wvalid_m1), .wready_m1(wready_m1), .w_pld_m1(w_pld_m1),
        .wvalid_s1(wvalid_s1), .wready_s1(wready_s1), .w_pld_s1(w_pld_s1),
        .arvalid_m1(arvalid_m1), .arready_m1(arready_m1), .ar_pld_m1(ar_pld_m1),
        .arvalid_s1(arvalid_s1), .arready_s1(arready_s1), .ar_pld_s1(ar_pld_s1),
        .rvalid_s1(rvalid_s1), .rready_s1(rready_s1), .r_pld_s1(r_pld_s1),
        .rvalid_m1(rvalid_m1), .rready_m1(rready_m1), .r_pld_m1(r_pld_m1),
        .bvalid_s1(bvalid_s1), .bready_s1(bready_s1), .b_pld_s1(b_pld_s1),
        .bvalid_m1(bvalid_m1), .bready_m1(bready_m1), .b_pld_m1(b_pld_m1)
`ifdef AXI_REG_SLICE_STATS_EN
        , .wr_done_cnt(wr_done_cnt), .rd_done_cnt(rd_done_cnt), .stall_cnt(stall_cnt)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;
    int w_pops = 0;
    int r_pops = 0;
    int ar_pops = 0;
    logic [AW_W-1:0] awq[$], arq[$];
    logic [W_W-1:0]  wq[$];
    logic [R_W-1:0]  rq[$];
    logic [B_W-1:0]  bq[$];
    logic aw_hold = 0, w_hold = 0, ar_hold = 0, r_hold = 0, b_hold = 0;
    logic [AW_W-1:0] aw_prev, ar_prev;
    logic [W_W-1:0]  w_prev;
    logic [R_W-1:0]  r_prev;
    logic [B_W-1:0]  b_prev;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic extra(input string nm, input logic [63:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got beat %0h expected none", nm, act);
    endtask

    function automatic logic [AW_W-1:0] mk_aw(input logic [15:0] a, input logic [7:0] id);
        return {a, 8'h03, 3'd2, 2'd1, 2'd0, 3'd0, 4'd3, id};
    endfunction
    function automatic logic [W_W-1:0] mk_w(input logic [31:0] d);
        return {d, 4'hF, 1'b1, d[7:0]};
    endfunction
    function automatic logic [R_W-1:0] mk_r(input logic [31:0] d, input logic last);
        return {d, last, 2'b00, d[7:0]};
    endfunction

    // Scoreboard: accepted source beats are queued, destination beats popped and compared; stalled outputs must hold
    always @(negedge aclk) begin
        if (areset) begin
            awq.delete(); wq.delete(); arq.delete(); rq.delete(); bq.delete();
            aw_hold = 0; w_hold = 0; ar_hold = 0; r_hold = 0; b_hold = 0;
        end else begin
            if (awvalid_m1 && awready_m1) awq.push_back(aw_pld_m1);
            if (wvalid_m1 && wready_m1) wq.push_back(w_pld_m1);
            if (arvalid_m1 && arready_m1) arq.push_back(ar_pld_m1);
            if (rvalid_s1 && rready_s1) rq.push_back(r_pld_s1);
            if (bvalid_s1 && bready_s1) bq.push_back(b_pld_s1);
            if (aw_hold) begin chk("aw_hold_v", awvalid_s1, 1); chk("aw_hold_p", aw_pld_s1, aw_prev); end
            if (w_hold) begin chk("w_hold_v", wvalid_s1, 1); chk("w_hold_p", w_pld_s1, w_prev); end
            if (ar_hold) begin chk("ar_hold_v", arvalid_s1, 1); chk("ar_hold_p", ar_pld_s1, ar_prev); end
            if (r_hold) begin chk("r_hold_v", rvalid_m1, 1); chk("r_hold_p", r_pld_m1, r_prev); end
            if (b_hold) begin chk("b_hold_v", bvalid_m1, 1); chk("b_hold_p", b_pld_m1, b_prev); end
            if (awvalid_s1 && awready_s1) begin
                if (awq.size() == 0) extra("aw_extra", aw_pld_s1); else chk("aw_order", aw_pld_s1, awq.pop_front());
            end
            if (wvalid_s1 && wready_s1) begin
                w_pops++;
                if (wq.size() == 0) extra("w_extra", w_pld_s1); else chk("w_order", w_pld_s1, wq.pop_front());
            end
            if (arvalid_s1 && arready_s1) begin
                ar_pops++;
                if (arq.size() == 0) extra("ar_extra", ar_pld_s1); else chk("ar_order", ar_pld_s1, arq.pop_front());
            end
            if (rvalid_m1 && rready_m1) begin
                r_pops++;
                if (rq.size() == 0) extra("r_extra", r_pld_m1); else chk("r_order", r_pld_m1, rq.pop_front());
            end
            if (bvalid_m1 && bready_m1) begin
                if (bq.size() == 0) extra("b_extra", b_pld_m1); else chk("b_order", b_pld_m1, bq.pop_front());
            end
            aw_hold = awvalid_s1 && !awready_s1; aw_prev = aw_pld_s1;
            w_hold = wvalid_s1 && !wready_s1; w_prev = w_pld_s1;
            ar_hold = arvalid_s1 && !arready_s1; ar_prev = ar_pld_s1;
            r_hold = rvalid_m1 && !rready_m1; r_prev = r_pld_m1;
            b_hold = bvalid_m1 && !bready_m1; b_prev = b_pld_m1;
        end
    end

    task automatic drain(input string nm);
        int left;
        for (int k = 0; k < 50; k++) begin
            left = awq.size() + wq.size() + arq.size() + rq.size() + bq.size();
            if (left == 0) break;
            @(negedge aclk);
        end
        left = awq.size() + wq.size() + arq.size() + rq.size() + bq.size();
        chk(nm, 64'(left), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        awvalid_m1 = 0; wvalid_m1 = 0; arvalid_m1 = 0; rvalid_s1 = 0; bvalid_s1 = 0;
        aw_pld_m1 = '0; w_pld_m1 = '0; ar_pld_m1 = '0; r_pld_s1 = '0; b_pld_s1 = '0;
        awready_s1 = 1; wready_s1 = 1; arready_s1 = 1; rready_m1 = 1; bready_m1 = 1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_awready", awready_m1, 0);
        chk("rst_rready_s1", rready_s1, 0);
        chk("rst_awvalid", awvalid_s1, 0);
        @(posedge aclk); #1 areset = 0;
        @(negedge aclk);
        chk("post_awvalid", awvalid_s1, 0);
        chk("post_wvalid", wvalid_s1, 0);
        chk("post_arvalid", arvalid_s1, 0);
        chk("post_rvalid", rvalid_m1, 0);
        chk("post_awready", awready_m1, 1);
        chk("post_rready_s1", rready_s1, 1);
        chk("post_aw_pld", aw_pld_s1, 0);

        // 8 back-to-back AW beats, 1-cycle latency, no bubbles
        for (int i = 0; i < 8; i++) begin
            @(posedge aclk); #1 awvalid_m1 = 1; aw_pld_m1 = mk_aw(16'(i), 8'(i));
            @(negedge aclk);
            chk("t1_awready", awready_m1, 1);
            chk("t1_awvalid", awvalid_s1, 64'(i > 0));
        end
        @(posedge aclk); #1 awvalid_m1 = 0;
        @(negedge aclk); chk("t1_last_valid", awvalid_s1, 1);
        @(negedge aclk); chk("t1_idle", awvalid_s1, 0);
        drain("t1_drain");

        // W backpressure fills main + skid, then releases in order
        w_pops = 0;
        @(posedge aclk); #1 wready_s1 = 0; wvalid_m1 = 1; w_pld_m1 = mk_w(32'h11);
        @(negedge aclk); chk("t2_rdy_empty", wready_m1, 1);
        @(posedge aclk); #1 w_pld_m1 = mk_w(32'h22);
        @(negedge aclk); chk("t2_rdy_one", wready_m1, 1);
        @(posedge aclk); #1 w_pld_m1 = mk_w(32'h33);
        @(negedge aclk); chk("t2_full", wready_m1, 0); chk("t2_head", w_pld_s1, mk_w(32'h11));
        @(posedge aclk); #1;
        @(negedge aclk); chk("t2_full_hold", wready_m1, 0);
        @(posedge aclk); #1 wready_s1 = 1;
        @(negedge aclk); chk("t2_rdy_reg", wready_m1, 0);
        @(posedge aclk); #1;
        @(negedge aclk); chk("t2_rdy_back", wready_m1, 1);
        @(posedge aclk); #1 wvalid_m1 = 0;
        drain("t2_drain");
        chk("t2_count", 64'(w_pops), 3);

        // R forward stage with rready_m1 toggling 1010
        r_pops = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    @(posedge aclk); #1 rvalid_s1 = 1; r_pld_s1 = mk_r(32'hA0 + 32'(i), i == 3);
                    @(negedge aclk);
                    for (int k = 0; k < 20 && !rready_s1; k++) @(negedge aclk);
                    if (!rready_s1) extra("t3_timeout", 64'(i));
                end
                @(posedge aclk); #1 rvalid_s1 = 0;
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    @(posedge aclk); #1 rready_m1 = (c % 2 == 0);
                end
                @(posedge aclk); #1 rready_m1 = 1;
            end
        join
        chk("t3_throughput", 64'(r_pops), 4);
        drain("t3_drain");

        // B bypass: same-cycle valid and ready, payload untouched
        @(posedge aclk); #1 bready_m1 = 0; bvalid_s1 = 1; b_pld_s1 = {2'b01, 8'h5A};
        @(negedge aclk);
        chk("t4_bvalid", bvalid_m1, 1);
        chk("t4_bpld", b_pld_m1, 10'h15A);
        chk("t4_bready0", bready_s1, 0);
        @(posedge aclk); #1 bready_m1 = 1;
        @(negedge aclk); chk("t4_bready1", bready_s1, 1);
        @(posedge aclk); #1 bvalid_s1 = 0;
        @(negedge aclk); chk("t4_bvalid_off", bvalid_m1, 0);
        drain("t4_drain");

        // Reset with two AR beats buffered discards them
        ar_pops = 0;
        @(posedge aclk); #1 arready_s1 = 0; arvalid_m1 = 1; ar_pld_m1 = mk_aw(16'h100, 8'h01);
        @(posedge aclk); #1 ar_pld_m1 = mk_aw(16'h200, 8'h02);
        @(posedge aclk); #1 arvalid_m1 = 0; areset = 1;
        @(negedge aclk);
        chk("t5_rst_arready", arready_m1, 0);
        chk("t5_rst_awready", awready_m1, 0);
        @(posedge aclk); #1 areset = 0;
        @(negedge aclk);
        chk("t5_arvalid", arvalid_s1, 0);
        chk("t5_awvalid", awvalid_s1, 0);
        chk("t5_wvalid", wvalid_s1, 0);
        chk("t5_rvalid", rvalid_m1, 0);
        chk("t5_ar_pld", ar_pld_s1, 0);
        chk("t5_arready", arready_m1, 1);
        @(posedge aclk); #1 arready_s1 = 1; arvalid_m1 = 1; ar_pld_m1 = mk_aw(16'h300, 8'h03);
        @(posedge aclk); #1 arvalid_m1 = 0;
        drain("t5_drain");
        chk("t5_ar_count", 64'(ar_pops), 1);

`ifdef AXI_REG_SLICE_STATS_EN
        // Counters: 3 B handshakes, 2 R-last beats, 4 AW stall cycles
        @(posedge aclk); #1 areset = 1;
        @(posedge aclk); #1 areset = 0;
        @(negedge aclk);
        chk("t6_wr0", wr_done_cnt, 0);
        chk("t6_rd0", rd_done_cnt, 0);
        chk("t6_st0", stall_cnt, 0);
        @(posedge aclk); #1 bvalid_s1 = 1; b_pld_s1 = 10'h0A1; rvalid_s1 = 1; r_pld_s1 = mk_r(32'hC1, 1);
        awready_s1 = 0; awvalid_m1 = 1; aw_pld_m1 = mk_aw(16'h400, 8'h04);
        @(posedge aclk); #1 awvalid_m1 = 0; r_pld_s1 = mk_r(32'hC2, 1);
        @(posedge aclk); #1 rvalid_s1 = 0;
        @(posedge aclk); #1 bvalid_s1 = 0;
        @(posedge aclk); #1;
        @(posedge aclk); #1 awready_s1 = 1;
        drain("t6_drain");
        @(negedge aclk);
        chk("t6_wr", wr_done_cnt, 3);
        chk("t6_rd", rd_done_cnt, 2);
        chk("t6_stall", stall_cnt, 4);
`endif

        repeat (2) @(negedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
